// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Purpose  : Shares the register file's single write port between the
//            pipeline WB stage (port 0, fixed priority, never stalled by
//            this block except during a forced grant) and a long-latency
//            unit (port 1, valid/ready). Port-1 writes are queued in a FIFO,
//            read hazards against queued writes are flagged, and port-1
//            starvation is broken by freezing the pipeline for one cycle.
// Options  : RFWA_BYPASS_EN - when defined, a port-1 write arriving with the
//            FIFO empty, a free slot and no forced grant goes straight to
//            the output register instead of through the FIFO.
// Ports    : clk_i, rst_i           clock / synchronous active-high reset
//            wb_we_i/addr/data      port 0 write request
//            p1_valid_i/ready_o     port 1 handshake
//            p1_addr_i/data_i       port 1 write payload
//            rs/rt_addr_i           decode-stage read addresses
//            rs/rt_pend_o           read address has a queued port-1 write
//            stall_o                pipeline freeze (forced grant cycle)
//            rf_we/waddr/wdata_o    registered register-file write port
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic        p1_valid_i,
  output logic        p1_ready_o,
  input  logic [4:0]  p1_addr_i,
  input  logic [31:0] p1_data_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  output logic        rs_pend_o,
  output logic        rt_pend_o,
  output logic        stall_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] C_FULL       = CW'(DEPTH);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_mem_addr [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [SW-1:0]    r_starve;
  logic [SW-1:0]    w_starve_nxt;
  logic             r_rf_we;
  logic [4:0]       r_rf_waddr;
  logic [31:0]      r_rf_wdata;

  logic w_slot_free;
  logic w_force;
  logic w_p0_wr;
  logic w_deq;
  logic w_xfer;
  logic w_bypass;
  logic w_enq;
  logic w_rs_hit;
  logic w_rt_hit;

  // A write to r0 does not occupy the register-file port.
  assign w_slot_free = !(wb_we_i && (wb_addr_i != 5'd0));
  assign w_force     = (r_state == ST_FORCE);
  // During a forced grant the pipeline is frozen and re-presents its WB
  // write next cycle, so port 0 is ignored here rather than dropped.
  assign w_p0_wr     = !w_slot_free && !w_force;
  assign w_deq       = (r_count != '0) && (w_slot_free || w_force);
  assign p1_ready_o  = (r_count != C_FULL);
  assign w_xfer      = p1_valid_i && p1_ready_o;

`ifdef RFWA_BYPASS_EN
  assign w_bypass = w_xfer && (r_count == '0) && !w_force && w_slot_free &&
                    (p1_addr_i != 5'd0);
`else
  assign w_bypass = 1'b0;
`endif

  // r0 writes from port 1 are accepted but never stored.
  assign w_enq       = w_xfer && (p1_addr_i != 5'd0) && !w_bypass;
  assign w_count_nxt = r_count + CW'(w_enq) - CW'(w_deq);

  // --------------------------------------------------------------------------
  // FSM: next state and starvation counter
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_count_nxt != '0) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // In DRAIN the FIFO is never empty, so no dequeue means blocked.
        if (w_deq) begin
          if (w_count_nxt == '0) w_state_nxt = ST_IDLE;
        end else if (r_starve == C_STARVE_MAX) begin
          w_state_nxt = ST_FORCE;
        end else begin
          w_starve_nxt = r_starve + SW'(1);
        end
      end
      ST_FORCE: begin
        w_state_nxt = (w_count_nxt != '0) ? ST_DRAIN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  assign stall_o = w_force;

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_deq) begin
        r_rd_ptr        <= r_rd_ptr + PW'(1);
        r_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_enq) begin
        r_wr_ptr        <= r_wr_ptr + PW'(1);
        r_vld[r_wr_ptr] <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; entry validity is tracked by r_vld.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem_addr[r_wr_ptr] <= p1_addr_i;
      r_mem_data[r_wr_ptr] <= p1_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Hazard detection against queued entries only
  // --------------------------------------------------------------------------
  always_comb begin
    w_rs_hit = 1'b0;
    w_rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_mem_addr[i] == rs_addr_i)) w_rs_hit = 1'b1;
      if (r_vld[i] && (r_mem_addr[i] == rt_addr_i)) w_rt_hit = 1'b1;
    end
  end

  assign rs_pend_o = w_rs_hit && (rs_addr_i != 5'd0);
  assign rt_pend_o = w_rt_hit && (rt_addr_i != 5'd0);

  // --------------------------------------------------------------------------
  // Output register. A dequeue only happens when port 0 is idle or ignored,
  // and bypass only when the FIFO is empty, so the sources never collide.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_deq) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= r_mem_addr[r_rd_ptr];
      r_rf_wdata <= r_mem_data[r_rd_ptr];
    end else if (w_p0_wr) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= wb_addr_i;
      r_rf_wdata <= wb_data_i;
    end else if (w_bypass) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= p1_addr_i;
      r_rf_wdata <= p1_data_i;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign rf_we_o    = r_rf_we;
  assign rf_waddr_o = r_rf_waddr;
  assign rf_wdata_o = r_rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Purpose  : Self-checking bench for rf_write_arbiter. A queue-based model
//            predicts every output each cycle; directed sequences add literal
//            expectations, followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef RFWA_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        p1_valid_i;
  logic        p1_ready_o;
  logic [4:0]  p1_addr_i;
  logic [31:0] p1_data_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic        rs_pend_o;
  logic        rt_pend_o;
  logic        stall_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .p1_valid_i(p1_valid_i), .p1_ready_o(p1_ready_o),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rs_pend_o(rs_pend_o), .rt_pend_o(rt_pend_o),
    .stall_o(stall_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: pending port-1 writes as a queue of {addr,data}
  // --------------------------------------------------------------------------
  logic [36:0] mq[$];
  bit          m_known = 1'b0;
  bit          m_force = 1'b0;
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  function automatic bit m_pend(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i][36:32] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int  sz;
    bit  slot_free, deq, xfer, byp;
    if (rst_i) begin
      mq.delete();
      m_known = 1'b1; m_force = 1'b0; m_starve = 0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      return;
    end
    sz        = mq.size();
    slot_free = !(wb_we_i && wb_addr_i != 0);
    deq       = (sz > 0) && (slot_free || m_force);
    xfer      = p1_valid_i && (sz < DEPTH);
    byp       = BYP && xfer && (sz == 0) && !m_force && slot_free && (p1_addr_i != 0);
    if (deq) begin
      m_we = 1'b1; m_waddr = mq[0][36:32]; m_wdata = mq[0][31:0];
    end else if (!m_force && !slot_free) begin
      m_we = 1'b1; m_waddr = wb_addr_i; m_wdata = wb_data_i;
    end else if (byp) begin
      m_we = 1'b1; m_waddr = p1_addr_i; m_wdata = p1_data_i;
    end else begin
      m_we = 1'b0;
    end
    if (deq) void'(mq.pop_front());
    if (xfer && p1_addr_i != 0 && !byp) mq.push_back({p1_addr_i, p1_data_i});
    // Starvation: count cycles the head sat blocked outside a forced grant.
    if (m_force) begin
      m_force = 1'b0; m_starve = 0;
    end else if (sz > 0 && !deq) begin
      if (m_starve == LIMIT - 1) begin
        m_force = 1'b1; m_starve = 0;
      end else begin
        m_starve++;
      end
    end else begin
      m_starve = 0;
    end
  endtask

  // One cycle: inputs already driven; check combinational outputs, clock,
  // advance model, check registered outputs on the falling edge.
  task automatic tick();
    #1;
    if (m_known) begin
      chk("p1_ready", {31'd0, p1_ready_o}, {31'd0, (mq.size() < DEPTH)});
      chk("stall",    {31'd0, stall_o},    {31'd0, m_force});
      chk("rs_pend",  {31'd0, rs_pend_o},  {31'd0, m_pend(rs_addr_i)});
      chk("rt_pend",  {31'd0, rt_pend_o},  {31'd0, m_pend(rt_addr_i)});
    end
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    chk("rf_we",    {31'd0, rf_we_o},    {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, m_waddr});
    chk("rf_wdata", rf_wdata_o, m_wdata);
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we_i = we; wb_addr_i = a; wb_data_i = d;
  endtask

  task automatic drive_p1(input logic v, input logic [4:0] a, input logic [31:0] d);
    p1_valid_i = v; p1_addr_i = a; p1_data_i = d;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
  endtask

  initial begin
    int          n;
    logic [4:0]  seen[$];
    logic [4:0]  exp_order[5];
    exp_order = '{5'd3, 5'd4, 5'd6, 5'd7, 5'd12};

    rst_i = 1'b1;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_p1(1'b0, 5'd0, 32'd0);
    rs_addr_i = 5'd0; rt_addr_i = 5'd0;
    @(negedge clk_i);

    // T1: reset held two cycles
    tick(); tick(); rst_i = 1'b0;
    #1;
    chk("T1 rf_we",    {31'd0, rf_we_o},    32'd0);
    chk("T1 rf_waddr", {27'd0, rf_waddr_o}, 32'd0);
    chk("T1 rf_wdata", rf_wdata_o,          32'd0);
    chk("T1 stall",    {31'd0, stall_o},    32'd0);
    chk("T1 ready",    {31'd0, p1_ready_o}, 32'd1);

    // T2: port-0 write and r0 idle slot
    drive_wb(1'b1, 5'd5, 32'hA5A5A5A5); tick();
    chk("T2 rf_we",    {31'd0, rf_we_o},    32'd1);
    chk("T2 rf_waddr", {27'd0, rf_waddr_o}, 32'd5);
    chk("T2 rf_wdata", rf_wdata_o,          32'hA5A5A5A5);
    drive_wb(1'b1, 5'd0, 32'h12345678); tick();
    chk("T2 r0 rf_we", {31'd0, rf_we_o},    32'd0);

    // T3: fill FIFO while port 0 occupies the slot
    drive_wb(1'b1, 5'd9, 32'h99);
    drive_p1(1'b1, 5'd3, 32'd1); tick();
    drive_p1(1'b1, 5'd4, 32'd2); tick();
    drive_p1(1'b1, 5'd6, 32'd3); tick();
    drive_p1(1'b1, 5'd7, 32'd4); tick();
    drive_p1(1'b0, 5'd0, 32'd0);
    rs_addr_i = 5'd4; rt_addr_i = 5'd0; #1;
    chk("T3 ready",   {31'd0, p1_ready_o}, 32'd0);
    chk("T3 rs_pend", {31'd0, rs_pend_o},  32'd1);
    chk("T3 rt_pend", {31'd0, rt_pend_o},  32'd0);

    // T5: full FIFO, slot freed, new request waits one cycle
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_p1(1'b1, 5'd12, 32'd5); #1;
    chk("T5 ready full", {31'd0, p1_ready_o}, 32'd0);
    tick();
    if (rf_we_o) seen.push_back(rf_waddr_o);
    #1;
    chk("T5 ready after deq", {31'd0, p1_ready_o}, 32'd1);
    tick();
    if (rf_we_o) seen.push_back(rf_waddr_o);
    drive_p1(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rf_we_o) seen.push_back(rf_waddr_o);
    end
    chk("T5 retire count", seen.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("T5 retire order", (i < seen.size()) ? {27'd0, seen[i]} : 32'hFFFF, {27'd0, exp_order[i]});

    // T4: starvation breaks after LIMIT blocked cycles
    rs_addr_i = 5'd0;
    do_reset();
    drive_wb(1'b1, 5'd9, 32'h90);
    drive_p1(1'b1, 5'd10, 32'hAB); tick();
    drive_p1(1'b0, 5'd0, 32'd0);
    n = 0;
    while (!stall_o && n < 20) begin
      tick(); n++;
    end
    chk("T4 blocked cycles", n, LIMIT);
    tick();
    chk("T4 forced we",    {31'd0, rf_we_o},    32'd1);
    chk("T4 forced addr",  {27'd0, rf_waddr_o}, 32'd10);
    chk("T4 forced data",  rf_wdata_o,          32'hAB);
    chk("T4 stall single", {31'd0, stall_o},    32'd0);
    tick();
    chk("T4 p0 kept addr", {27'd0, rf_waddr_o}, 32'd9);
    chk("T4 p0 kept data", rf_wdata_o,          32'h90);

    // T6: latency into empty FIFO, and reset dropping queued entries
    drive_wb(1'b0, 5'd0, 32'd0);
    do_reset();
    drive_p1(1'b1, 5'd8, 32'h88); tick();
    drive_p1(1'b0, 5'd0, 32'd0);
    chk("T6 we N+1", {31'd0, rf_we_o}, {31'd0, BYP});
    tick();
    chk("T6 we N+2", {31'd0, rf_we_o}, {31'd0, !BYP});
    chk("T6 addr",   {27'd0, rf_waddr_o}, 32'd8);
    drive_wb(1'b1, 5'd9, 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive_p1(1'b1, 5'(13 + i), 32'(i)); tick();
    end
    drive_p1(1'b0, 5'd0, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("T6 no write after rst", {31'd0, rf_we_o}, 32'd0);
    end

    // Randomized traffic with varying port-0 load
    for (int blk = 0; blk < 30; blk++) begin
      int busy;
      busy = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++) begin
        rst_i = ($urandom_range(0, 299) == 0);
        drive_wb(($urandom_range(0, 99) < busy), 5'($urandom_range(0, 7)), $urandom);
        drive_p1($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        rs_addr_i = 5'($urandom_range(0, 7));
        rt_addr_i = 5'($urandom_range(0, 7));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
